// File: rtl/divider_ctrl.sv
// Sequencing FSM for the 8-bit non-restoring shift/add/sub divider datapath.
// Optional macro DIVIDER_CTRL_STEP_EN adds a step input that gates every advance and strobe.
module divider_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
`ifdef DIVIDER_CTRL_STEP_EN
    input  logic             step,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] divisor,
    input  logic             sign_rem,
    output logic             load,
    output logic             shift_en,
    output logic             count_en,
    output logic             add_en,
    output logic             sub_en,
    output logic             final_add,
    output logic             busy,
    output logic             done,
    output logic             dz_err
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StAddSub,
        StFix,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_sub_q, op_sub_d;
    logic             dz_err_q, dz_err_d;
    logic             adv;

`ifdef DIVIDER_CTRL_STEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_sub_q <= 1'b1;
            dz_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_sub_q <= op_sub_d;
            dz_err_q <= dz_err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_sub_d = op_sub_q;
        dz_err_d = dz_err_q;
        unique case (state_q)
            StIdle: begin
                // Start is accepted in IDLE regardless of step.
                if (start) begin
                    if (divisor != '0) begin
                        dz_err_d = 1'b0;
                        state_d  = StLoad;
                    end else begin
                        dz_err_d = 1'b1;
                        state_d  = StDone;
                    end
                end
            end
            StLoad: begin
                if (adv) state_d = StShift;
            end
            StShift: begin
                // sign_rem is still the pre-shift remainder sign at this edge.
                if (adv) begin
                    op_sub_d = ~sign_rem;
                    state_d  = StAddSub;
                end
            end
            StAddSub: begin
                if (adv) begin
                    if (cnt_q == LastIter) begin
                        cnt_d   = '0;
                        state_d = StFix;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = StShift;
                    end
                end
            end
            StFix: begin
                if (adv) state_d = StDone;
            end
            StDone: begin
                if (adv) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        load      = (state_q == StLoad) && adv;
        shift_en  = (state_q == StShift) && adv;
        count_en  = shift_en;
        sub_en    = (state_q == StAddSub) && op_sub_q && adv;
        add_en    = (state_q == StAddSub) && !op_sub_q && adv;
        final_add = (state_q == StFix) && adv;
        done      = (state_q == StDone) && adv;
        busy      = (state_q == StLoad) || (state_q == StShift) || (state_q == StAddSub) ||
                    (state_q == StFix);
        dz_err    = dz_err_q;
    end

endmodule

// File: tb/tb_divider_ctrl.sv
// Bench for divider_ctrl: a small datapath model closes the loop, results are
// compared against plain integer division and the documented cycle timing.
module tb_divider_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] divisor = 8'd0;
    logic [7:0] dividend = 8'd0;
    logic       sign_rem;
    logic       load, shift_en, count_en, add_en, sub_en, final_add, busy, done, dz_err;
`ifdef DIVIDER_CTRL_STEP_EN
    logic       step = 1'b1;
`endif

    int errors = 0;
    int checks = 0;

    divider_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef DIVIDER_CTRL_STEP_EN
        .step      (step),
`endif
        .start     (start),
        .divisor   (divisor),
        .sign_rem  (sign_rem),
        .load      (load),
        .shift_en  (shift_en),
        .count_en  (count_en),
        .add_en    (add_en),
        .sub_en    (sub_en),
        .final_add (final_add),
        .busy      (busy),
        .done      (done),
        .dz_err    (dz_err)
    );

    always #5 clk = ~clk;

    // Non-restoring datapath: signed partial remainder acc, quotient/dividend register quo.
    int         acc = 0;
    int         mdiv = 0;
    logic [7:0] quo = 8'd0;
    assign sign_rem = (acc < 0);

    always @(posedge clk) begin
        if (load) begin
            acc  <= 0;
            quo  <= dividend;
            mdiv <= int'(divisor);
        end else if (shift_en) begin
            acc <= acc * 2 + int'(quo[7]);
            quo <= {quo[6:0], 1'b0};
        end else if (sub_en) begin
            acc <= acc - mdiv;
            quo <= {quo[7:1], ((acc - mdiv) >= 0)};
        end else if (add_en) begin
            acc <= acc + mdiv;
            quo <= {quo[7:1], ((acc + mdiv) >= 0)};
        end else if (final_add) begin
            if (acc < 0) acc <= acc + mdiv;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int n_strobes();
        return int'(load) + int'(shift_en) + int'(add_en) + int'(sub_en) + int'(final_add);
    endfunction

    // One division from IDLE; start optionally re-pulsed at cycle poke_cyc.
    task automatic run_div(input string tag, input logic [7:0] dd, input logic [7:0] dv,
                           input int poke_cyc);
        int n_load = 0, n_shift = 0, n_addsub = 0, n_fix = 0, n_busy = 0, n_done = 0;
        int done_cyc = 0, first_sub = -1, viol = 0, dz_first = -1;
        int q_got = -1, r_got = -1;
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 22; cyc++) begin
            start = (cyc == poke_cyc);
            if (cyc == 1) dz_first = int'(dz_err);
            n_load   += int'(load);
            n_shift  += int'(shift_en);
            n_addsub += int'(add_en) + int'(sub_en);
            n_fix    += int'(final_add);
            n_busy   += int'(busy);
            if (n_strobes() > 1 || count_en !== shift_en) viol++;
            if (first_sub < 0 && (add_en || sub_en)) first_sub = int'(sub_en);
            if (done) begin
                n_done++;
                if (done_cyc == 0) begin
                    done_cyc = cyc;
                    q_got    = int'(quo);
                    r_got    = acc;
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({tag, ".viol"}, viol, 0);
        chk({tag, ".ndone"}, n_done, 1);
        if (dv != 8'd0) begin
            chk({tag, ".load"}, n_load, 1);
            chk({tag, ".shift"}, n_shift, 8);
            chk({tag, ".addsub"}, n_addsub, 8);
            chk({tag, ".fix"}, n_fix, 1);
            chk({tag, ".busy"}, n_busy, 18);
            chk({tag, ".done_cyc"}, done_cyc, 19);
            chk({tag, ".first_sub"}, first_sub, 1);
            chk({tag, ".quo"}, q_got, int'(dd) / int'(dv));
            chk({tag, ".rem"}, r_got, int'(dd) % int'(dv));
            chk({tag, ".dz"}, dz_first, 0);
        end else begin
            chk({tag, ".strobes"}, n_load + n_shift + n_addsub + n_fix, 0);
            chk({tag, ".busy"}, n_busy, 0);
            chk({tag, ".done_cyc"}, done_cyc, 1);
            chk({tag, ".dz"}, dz_first, 1);
            chk({tag, ".dz_sticky"}, int'(dz_err), 1);
        end
    endtask

    initial begin
        int load_cycles[$];
        int drained;
        int busy_gap;

        // Asynchronous reset: outputs must drop before any clock edge.
        #1 reset = 1'b0;
        #1;
        chk("rst.strobes", n_strobes(), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.dz", int'(dz_err), 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run_div("d20_3", 8'd20, 8'd3, 0);
        run_div("d201_5", 8'd201, 8'd5, 0);
        run_div("dz", 8'd50, 8'd0, 0);
        run_div("dz_clr_poke", 8'd77, 8'd7, 5);
        run_div("d255_1", 8'd255, 8'd1, 0);
        run_div("d3_255", 8'd3, 8'd255, 0);
        for (int i = 0; i < 6; i++) begin
            run_div($sformatf("rnd%0d", i), 8'($urandom_range(0, 255)),
                    8'($urandom_range(1, 255)), 0);
        end

        // Start held high: exactly one IDLE cycle between back-to-back divisions.
        dividend = 8'd100;
        divisor  = 8'd9;
        start    = 1'b1;
        busy_gap = -1;
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 21; cyc++) begin
            if (load) load_cycles.push_back(cyc);
            if (cyc == 20) busy_gap = int'(busy) + int'(load) + int'(done);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("hold.nload", load_cycles.size(), 2);
        if (load_cycles.size() == 2) begin
            chk("hold.load1", load_cycles[0], 1);
            chk("hold.load2", load_cycles[1], 21);
        end
        chk("hold.gap", busy_gap, 0);
        drained = 0;
        for (int cyc = 0; cyc < 25 && drained == 0; cyc++) begin
            if (done) drained = 1;
            @(posedge clk); #1;
        end
        chk("hold.drain", drained, 1);

        // Reset mid-division at cycle 9, then a clean division.
        dividend = 8'd150;
        divisor  = 8'd11;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 9; cyc++) begin
            @(posedge clk); #1;
        end
        chk("abort.pre_busy", int'(busy), 1);
        #2 reset = 1'b0;
        #1;
        chk("abort.strobes", n_strobes(), 0);
        chk("abort.busy", int'(busy), 0);
        chk("abort.done", int'(done), 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort.idle", int'(busy) + n_strobes() + int'(done), 0);
        run_div("post_rst", 8'd150, 8'd11, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
